// File: rtl/logical_shift_unit.sv
// Logical shift unit: zero-fill SLL/SRL barrel networks plus a registered, direction-selected result stage.
// Latency: out_sll/out_srl are combinational (0 cycles); res_q/valid_q follow valid_in by 1 cycle.
// Backpressure: none; one capture per cycle whenever valid_in is high, valid_q is never stalled.
module logical_shift_unit #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in,
    input  logic [$clog2(N)-1:0] shamt,
    input  logic                 dir,
    input  logic                 valid_in,
    output logic [N-1:0]         out_sll,
    output logic [N-1:0]         out_srl,
    output logic [N-1:0]         res_q,
    output logic                 valid_q
);

    localparam int SW = $clog2(N);

    // Stage k holds the operand after the shifts selected by shamt[k-1:0];
    // stage 0 is the raw operand, stage SW is the final result.
    logic [SW:0][N-1:0] sll_stage;
    logic [SW:0][N-1:0] srl_stage;

    logic [N-1:0] res_d;
    logic         valid_d;

    assign sll_stage[0] = in;
    assign srl_stage[0] = in;

    // Log2(N) mux stages: stage k moves the data by 2^k when shamt[k] is set.
    // The vacated positions are always zero-filled, so SRL never sign-extends.
    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int S = 1 << k;

        assign sll_stage[k+1] = shamt[k] ? {sll_stage[k][N-1-S:0], {S{1'b0}}}
                                         : sll_stage[k];
        assign srl_stage[k+1] = shamt[k] ? {{S{1'b0}}, srl_stage[k][N-1:S]}
                                         : srl_stage[k];
    end

    assign out_sll = sll_stage[SW];
    assign out_srl = srl_stage[SW];

    // Next-state for the result stage: capture the selected shift on valid_in, otherwise hold data and drop valid.
    always_comb begin
        res_d   = res_q;
        valid_d = 1'b0;
        if (valid_in) begin
            res_d   = dir ? out_srl : out_sll;
            valid_d = 1'b1;
        end
    end

    // Result registers; reset clears both immediately and wins over any same-cycle capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_logical_shift_unit.sv
module tb_logical_shift_unit;

    localparam int N = 32;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  in;
    logic [4:0]    shamt;
    logic          dir;
    logic          valid_in;
    logic [N-1:0]  out_sll;
    logic [N-1:0]  out_srl;
    logic [N-1:0]  res_q;
    logic          valid_q;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] exp_q[$];

    logical_shift_unit #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .shamt    (shamt),
        .dir      (dir),
        .valid_in (valid_in),
        .out_sll  (out_sll),
        .out_srl  (out_srl),
        .res_q    (res_q),
        .valid_q  (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every presented result is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (valid_q === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got res_q 0x%08h with no expected entry", res_q);
            end else begin
                check("scoreboard_res", res_q, exp_q.pop_front());
            end
        end
    end

    // Combinational directed vector with hand-computed results.
    task automatic comb_vec(input logic [N-1:0] v, input logic [4:0] s,
                            input logic [N-1:0] e_sll, input logic [N-1:0] e_srl);
        in    = v;
        shamt = s;
        #1;
        check("comb_sll", out_sll, e_sll);
        check("comb_srl", out_srl, e_srl);
    endtask

    // Registered-path request: drive after a rising edge and queue the expected capture.
    task automatic issue(input logic [N-1:0] v, input logic [4:0] s, input logic d,
                         input logic [N-1:0] e);
        @(posedge clk);
        #1;
        in       = v;
        shamt    = s;
        dir      = d;
        valid_in = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    initial begin
        logic [N-1:0] v;
        int wait_cyc;

        rst_n    = 1'b0;
        in       = '0;
        shamt    = '0;
        dir      = 1'b0;
        valid_in = 1'b0;

        // Reset state before any clock edge (asynchronous clear).
        #3;
        check("reset_res_q", res_q, 32'h0);
        check("reset_valid_q", {31'h0, valid_q}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational directed vectors.
        comb_vec(32'h8000_0001, 5'd0,  32'h8000_0001, 32'h8000_0001);
        comb_vec(32'h8000_0001, 5'd1,  32'h0000_0002, 32'h4000_0000);
        comb_vec(32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 32'h0000_0001);
        comb_vec(32'h1234_5678, 5'd4,  32'h2345_6780, 32'h0123_4567);
        comb_vec(32'h1234_5678, 5'd16, 32'h5678_0000, 32'h0000_1234);
        comb_vec(32'h7FFF_FFFE, 5'd31, 32'h0000_0000, 32'h0000_0000);

        // Random sweep against the reference shift expressions.
        for (int i = 0; i < 1000; i++) begin
            v = $urandom;
            for (int s = 0; s < 32; s++) begin
                in    = v;
                shamt = s[4:0];
                #1;
                check("sweep_sll", out_sll, v << s);
                check("sweep_srl", out_srl, v >> s);
            end
        end

        // Registered path: SRL capture, then SLL capture, then idle hold.
        issue(32'h0000_00F0, 5'd4, 1'b1, 32'h0000_000F);
        issue(32'h0000_00F0, 5'd4, 1'b0, 32'h0000_0F00);
        idle();
        @(posedge clk);
        #1;
        check("hold_valid_q", {31'h0, valid_q}, 32'h0);
        check("hold_res_q", res_q, 32'h0000_0F00);

        // Back-to-back captures with boundary shift amounts.
        issue(32'h8000_0001, 5'd0,  1'b1, 32'h8000_0001);
        issue(32'h8000_0001, 5'd1,  1'b1, 32'h4000_0000);
        issue(32'hFFFF_FFFF, 5'd31, 1'b0, 32'h8000_0000);
        issue(32'h8000_0000, 5'd31, 1'b1, 32'h0000_0001);

        // Mid-operation reset: last capture is visible, a new request is pending.
        @(posedge clk);
        #1;
        in       = 32'h0000_00F0;
        shamt    = 5'd4;
        dir      = 1'b1;
        valid_in = 1'b1;
        @(negedge clk);
        #1;
        check("pre_reset_valid_q", {31'h0, valid_q}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_reset_res_q", res_q, 32'h0);
        check("async_reset_valid_q", {31'h0, valid_q}, 32'h0);
        @(posedge clk);
        #1;
        check("reset_drop_res_q", res_q, 32'h0);
        check("reset_drop_valid_q", {31'h0, valid_q}, 32'h0);

        // Release reset with valid_in still high: capture resumes on the next edge.
        rst_n = 1'b1;
        exp_q.push_back(32'h0000_000F);
        idle();
        #1;
        check("resume_res_q", res_q, 32'h0000_000F);

        // Drain the scoreboard within a bounded number of cycles.
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
